// File: rtl/sram_uart_dump.sv
// sram_uart_dump: reads a window of SRAM words and
// sends each word as 4 UART 8N1 bytes, LSB first.
module sram_uart_dump #(
  parameter int CLK_DIV = 434,
  parameter int ADDR_W  = 22
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dump_go,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              mem_sram_cs,
  output logic              mem_sram_rw,
  output logic [ADDR_W-1:0] mem_sram_addr,
  output logic [31:0]       mem_sram_data_wr,
  input  logic [31:0]       mem_sram_data_rd,
  input  logic              mem_sram_done,
  output logic              uart_txd
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    TX,
    NEXT,
    FIN
  } state_t;

  state_t            state;
  logic [BW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic [31:0]       buf_q;
  logic [ADDR_W-1:0] rem;

  assign mem_sram_rw      = 1'b0;
  assign mem_sram_data_wr = '0;

  // Control FSM: fetch a word, shift out 4 frames, advance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      byte_idx      <= '0;
      buf_q         <= '0;
      rem           <= '0;
      mem_sram_addr <= '0;
      mem_sram_cs   <= 1'b0;
      dump_busy     <= 1'b0;
      dump_done     <= 1'b0;
      uart_txd      <= 1'b1;
    end else begin
      dump_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_go) begin
            mem_sram_addr <= dump_base;
            rem           <= dump_len;
            dump_busy     <= 1'b1;
            if (dump_len == '0) begin
              state <= FIN;
            end else begin
              state       <= REQ;
              mem_sram_cs <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_sram_done) begin
            buf_q       <= mem_sram_data_rd;
            mem_sram_cs <= 1'b0;
            byte_idx    <= '0;
            bit_cnt     <= '0;
            baud_cnt    <= '0;
            uart_txd    <= 1'b0;
            state       <= TX;
          end
        end
        TX: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              buf_q   <= buf_q >> 8;
              if (byte_idx == 2'd3) begin
                state <= NEXT;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                uart_txd <= 1'b0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              uart_txd <= (bit_cnt == 4'd8) ? 1'b1
                                            : buf_q[bit_cnt[2:0]];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        NEXT: begin
          mem_sram_addr <= mem_sram_addr + ADDR_W'(1);
          rem           <= rem - ADDR_W'(1);
          if (rem == ADDR_W'(1)) begin
            state <= FIN;
          end else begin
            state       <= REQ;
            mem_sram_cs <= 1'b1;
          end
        end
        FIN: begin
          dump_done <= 1'b1;
          dump_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_uart_dump.md
Name: sram_uart_dump

Overview:
- Read-back counterpart of the boot copier: that block fills SRAM from flash, and this block reads a window of SRAM words back out.
- It uses the same mem_sram cs/rw/done handshake that the memory interface serves.
- It serialises each word as 4 bytes on a UART 8N1 transmitter, least-significant byte first.
- It sits beside the boot copier in MEM and shares the SRAM port through the existing mux. Its purpose is to verify the boot image over the serial link.

Parameters:
- CLK_DIV, 434: clk_in cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.
- ADDR_W, 22: SRAM word-address width.

Ports:
- clk_in  in  1  system clock; all logic is on the rising edge.
- rst_in  in  1  synchronous reset, active-high.
- dump_go  in  1  one-cycle start pulse. Sampled only in IDLE.
- dump_base  in  ADDR_W  first word address. Latched on the accepted dump_go.
- dump_len  in  ADDR_W  number of words. Latched on the accepted dump_go. 0 means no transfer.
- dump_busy  out  1  high from the cycle after an accepted go until dump_done.
- dump_done  out  1  one-cycle completion pulse.
- mem_sram_cs  out  1  request to the SRAM interface. Held until done.
- mem_sram_rw  out  1  constant 0 (read).
- mem_sram_addr  out  ADDR_W  word address of the current request.
- mem_sram_data_wr  out  32  constant 0.
- mem_sram_data_rd  in  32  read data. Valid in the cycle mem_sram_done=1.
- mem_sram_done  in  1  one-cycle acknowledge from the SRAM interface.
- uart_txd  out  1  serial output. Idles at 1.

Behaviour:
- Reset (rst_in=1 at a clock edge), all outputs:
  - uart_txd=1
  - mem_sram_cs=0, mem_sram_addr=0
  - dump_busy=0, dump_done=0
  - internal state IDLE; bit counter, baud counter, byte index and word counter cleared.
- Reset applied mid-operation aborts immediately, even mid-bit:
  - uart_txd returns to 1 on the next edge.
  - cs drops.
  - No dump_done is issued.
- States: IDLE, REQ, TX, NEXT, FIN.
- IDLE:
  - dump_go=1 latches base and len and sets busy.
  - If len=0, go to FIN. Otherwise go to REQ.
  - dump_go outside IDLE is ignored, with no side effects.
- REQ:
  - cs=1, addr = current address; rw and data_wr stay 0.
  - cs is held until mem_sram_done is sampled 1.
  - On that edge: capture data_rd into a 32-bit shift buffer, drop cs in the same edge, set byte index to 0, go to TX.
  - A done arriving while cs=0 is ignored.
- TX, one frame per byte:
  - Frame is start bit (0), 8 data bits LSB first, stop bit (1).
  - Each bit is driven for exactly CLK_DIV cycles. The baud counter reloads at every bit boundary.
  - uart_txd goes to 0 on the first TX cycle, with no idle gap.
  - Bytes are sent in order buf[7:0], buf[15:8], buf[23:16], buf[31:24].
  - Consecutive bytes follow back to back: stop bit, then the next start bit.
  - After the stop bit of byte 3, go to NEXT.
- NEXT (1 cycle):
  - addr = addr+1, modulo 2^ADDR_W, so 0x3FFFFF wraps to 0x000000.
  - Remaining count is decremented. If remaining = 0 go to FIN, else go to REQ.
- FIN (1 cycle): dump_done=1 and busy drops in the same cycle. Then return to IDLE.
- uart_txd is 1 in every state except TX data and start bits.
- Timing per word:
  - SRAM latency (cs rising to done) plus 1 cycle, plus 40*CLK_DIV cycles of TX, plus 1 NEXT cycle.
  - There is no TX gap inside a word. Between words txd idles at 1 for the NEXT + REQ cycles.
- Word count is unsigned. dump_len=0x3FFFFF dumps all words except one, with no overflow.

Test Plan:
- Reset (CLK_DIV=4): hold rst_in for 3 cycles, then release → txd=1, cs=0, busy=0, done=0; dump_go is ignored for zero cycles (accepted immediately after release).
- Single word (CLK_DIV=4): base=0x000010, len=1, SRAM model returns 0x44332211 after 3 cycles →
  - one cs request at addr 0x000010 with rw=0;
  - txd decodes to bytes 0x11, 0x22, 0x33, 0x44, each bit 4 cycles wide;
  - one dump_done pulse, then busy=0.
- len=0 → busy rises, dump_done pulses 2 cycles after go, cs never asserted, txd stays 1.
- Multi-word with wrap: base=0x3FFFFE, len=3, data 0xA5A5A5A5, 0x00000001, 0xFFFFFFFF →
  - addresses 0x3FFFFE, 0x3FFFFF, 0x000000;
  - 12 bytes on txd in order A5 A5 A5 A5 01 00 00 00 FF FF FF FF.
- Go while busy: a second dump_go mid-transfer with a different base/len → ignored; the original transfer completes unchanged.
- Reset mid-frame: assert rst_in during data bit 3 of byte 1 → next edge txd=1, cs=0, no done; a fresh go then dumps correctly.
